return_stack: RTL and testbench
===============================

// Module: return_stack
// PURPOSE
//   Hardware return-address stack; successor to the single-entry Stack register in the A09 CPU.
//   Holds up to Depth return addresses, so calls can nest (JPL pushes, RET pops).
//   Sits between the PC output (push data) and the MUX_PC return-address input (DOut).
//   Also adds full/empty status, sticky overflow/underflow error flags and a selectable full-policy.
// PARAMETERS
//   DataWidth  8  width of one stored address
//   Depth      4  number of entries; power of two, >= 2
//   WrapMode   0  0 = reject push when full; 1 = circular, overwrite oldest entry
// PORTS
//   Clk        in   1                   system clock, rising edge
//   Reset      in   1                   asynchronous, active-low; clears all state
//   Push       in   1                   push DIn this cycle
//   Pop        in   1                   pop top entry this cycle
//   DIn        in   DataWidth           address to push (PC, already at next instruction)
//   ErrClr     in   1                   clear Overflow/Underflow
//   DOut       out  DataWidth           current top of stack; 0 when Empty
//   Empty      out  1                   Count == 0
//   Full       out  1                   Count == Depth
//   Count      out  clog2(Depth+1)      live entries
//   Overflow   out  1                   sticky: push attempted while Full
//   Underflow  out  1                   sticky: pop attempted while Empty
// BEHAVIOUR
//   Reset (Reset=0, async): Count=0, top pointer=0, Overflow=Underflow=0, Empty=1, Full=0, DOut=0.
//     Entry RAM is not reset.
//   Storage: Depth x DataWidth register array, circular top pointer TopPtr [clog2(Depth)-1:0].
//   DOut is combinational from mem[TopPtr-1] (mod Depth), gated to 0 when Empty.
//   A push is visible on DOut the cycle after the edge; a pop exposes the previous entry the cycle after.
//   Per rising edge, priority in this order:
//   - Push & Pop, !Empty: overwrite top with DIn; Count and TopPtr unchanged.
//   - Push & Pop, Empty: Underflow<=1; push proceeds; Count=1.
//   - Push only, !Full: mem[TopPtr]<=DIn; TopPtr+1; Count+1.
//   - Push only, Full, WrapMode=0: no state change; Overflow<=1.
//   - Push only, Full, WrapMode=1: mem[TopPtr]<=DIn; TopPtr+1, wrapping so the oldest entry is lost;
//     Count stays Depth; Overflow<=1.
//   - Pop only, !Empty: TopPtr-1; Count-1.
//   - Pop only, Empty: no state change; Underflow<=1.
//   - ErrClr clears both flags; an error raised in the same cycle wins (flag ends 1).
//   Pointer arithmetic is modulo Depth (natural wrap of clog2(Depth) bits).
//   Count is saturating 0..Depth and is never wrapped.
//   Reset asserted mid-operation takes effect immediately, regardless of Clk, Push or Pop.
// CONFIGURATION
//   `RSTK_HIGHWATER_EN defined:
//     - adds output HighWater [clog2(Depth+1)-1:0], the maximum Count reached since reset.
//     - updates on the edge where Count increases; reset to 0; not cleared by ErrClr.
//   Not defined: the port and its register are absent; all other behaviour is identical.
// STRUCTURE
//   Shared constants include (alongside the sequence-control constants):
//     - WRAP_REJECT = 0, WRAP_CIRCULAR = 1 for WrapMode.
//     - the clog2-derived width helpers (PtrBits, CountBits).
//   One sub-module, stack_pointer: TopPtr/Count up/down counter with saturation and the Full/Empty decode.
//   return_stack holds the entry array, DOut gating and the error flags.
//   CPU integration: the Stack Register is replaced; STK_Ld drives Push, and the sequencer's RET state drives Pop.
// TESTING
//   1 Reset low, then high -> Empty=1, Full=0, Count=0, DOut=0x00, Overflow=Underflow=0.
//   2 Push 0x10, 0x20, 0x30 -> DOut=0x30, Count=3; one Pop -> DOut=0x20, Count=2.
//   3 Depth=4, WrapMode=0: push 1,2,3,4 (Full=1); push 5 -> Overflow=1, DOut=4, Count=4;
//     pops then return 4,3,2,1 and Empty=1.
//   4 Depth=4, WrapMode=1: push 1..5 -> Overflow=1, DOut=5, Count=4;
//     pops return 5,4,3,2 and Empty=1.
//   5 Pop on empty -> Underflow=1, Count=0, DOut=0;
//     ErrClr with Pop on empty in the same cycle -> Underflow stays 1;
//     ErrClr alone -> Underflow=0.
//   6 Top=0x20, Count=2; Push&Pop with DIn=0x55 -> DOut=0x55, Count=2;
//     then assert Reset mid-cycle -> Count=0 and Empty=1 immediately.
//     With `RSTK_HIGHWATER_EN, HighWater=2 before that reset and 0 after.

Source files
------------

// File: rtl/return_stack_pkg.sv
// Shared definitions for the return-address stack: full-policy constants,
// the per-edge stack operation code and the width helpers.
package return_stack_pkg;

  // Full-policy selection for the WrapMode parameter
  localparam int WRAP_REJECT   = 0;
  localparam int WRAP_CIRCULAR = 1;

  // Operation applied to the stack on one clock edge, resolved from Push/Pop
  // and the current Full/Empty state
  typedef enum logic [2:0] {
    OP_IDLE,       // nothing happens
    OP_PUSH,       // write at top pointer, pointer and count advance
    OP_PUSH_WRAP,  // full circular push: pointer advances, count stays at Depth
    OP_POP,        // pointer and count retreat
    OP_REPLACE,    // simultaneous push and pop: top entry rewritten in place
    OP_REJECT,     // push while full without wrap: no state change
    OP_POP_EMPTY   // pop while empty: no state change
  } stack_op_e;

  // Bits needed to address Depth entries
  function automatic int ptr_bits(input int depth);
    return $clog2(depth);
  endfunction

  // Bits needed to hold a count of 0..Depth
  function automatic int count_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack_if.sv
// Push/pop and status bundle between the CPU sequencer (master) and the
// return stack (slave). HighWater exists only when RSTK_HIGHWATER_EN is defined.
interface return_stack_if #(
  parameter int DataWidth = 8,
  parameter int Depth     = 4
);
  localparam int CountBits = return_stack_pkg::count_bits(Depth);

  logic                 Push;
  logic                 Pop;
  logic [DataWidth-1:0] DIn;
  logic                 ErrClr;
  logic [DataWidth-1:0] DOut;
  logic                 Empty;
  logic                 Full;
  logic [CountBits-1:0] Count;
  logic                 Overflow;
  logic                 Underflow;
`ifdef RSTK_HIGHWATER_EN
  logic [CountBits-1:0] HighWater;

  modport master (
    output Push, Pop, DIn, ErrClr,
    input  DOut, Empty, Full, Count, Overflow, Underflow, HighWater
  );
  modport slave (
    input  Push, Pop, DIn, ErrClr,
    output DOut, Empty, Full, Count, Overflow, Underflow, HighWater
  );
`else
  modport master (
    output Push, Pop, DIn, ErrClr,
    input  DOut, Empty, Full, Count, Overflow, Underflow
  );
  modport slave (
    input  Push, Pop, DIn, ErrClr,
    output DOut, Empty, Full, Count, Overflow, Underflow
  );
`endif
endinterface

// File: rtl/return_stack_stack_pointer.sv
// Top-pointer / entry-count tracker for the return stack. The pointer wraps
// naturally modulo Depth; the count saturates at 0 and Depth.
module return_stack_stack_pointer
  import return_stack_pkg::*;
#(
  parameter  int Depth     = 4,
  localparam int PtrBits   = ptr_bits(Depth),
  localparam int CountBits = count_bits(Depth)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  stack_op_e            op,
  output logic [PtrBits-1:0]   top_ptr,
  output logic [CountBits-1:0] count,
  output logic [CountBits-1:0] count_next,
  output logic                 full,
  output logic                 empty
);

  localparam logic [PtrBits-1:0]   PTR_ONE    = PtrBits'(1);
  localparam logic [CountBits-1:0] COUNT_ONE  = CountBits'(1);
  localparam logic [CountBits-1:0] COUNT_FULL = CountBits'(Depth);

  logic [PtrBits-1:0]   top_ptr_q, top_ptr_d;
  logic [CountBits-1:0] count_q,   count_d;

  // Next pointer/count for the resolved operation
  always_comb begin
    top_ptr_d = top_ptr_q;
    count_d   = count_q;
    case (op)
      OP_PUSH: begin
        top_ptr_d = top_ptr_q + PTR_ONE;
        if (count_q != COUNT_FULL) count_d = count_q + COUNT_ONE;
      end
      OP_PUSH_WRAP: begin
        // oldest entry is overwritten, so the live count does not change
        top_ptr_d = top_ptr_q + PTR_ONE;
      end
      OP_POP: begin
        top_ptr_d = top_ptr_q - PTR_ONE;
        if (count_q != '0) count_d = count_q - COUNT_ONE;
      end
      default: ;
    endcase
  end

  // Pointer and count registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      top_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      top_ptr_q <= top_ptr_d;
      count_q   <= count_d;
    end
  end

  assign top_ptr    = top_ptr_q;
  assign count      = count_q;
  assign count_next = count_d;
  assign full       = (count_q == COUNT_FULL);
  assign empty      = (count_q == '0);

endmodule

// File: rtl/return_stack.sv
// Multi-entry hardware return-address stack (JPL pushes, RET pops).
// Holds the entry array, DOut gating and the sticky Overflow/Underflow flags;
// pointer/count bookkeeping lives in return_stack_stack_pointer.
// Optional feature: define RSTK_HIGHWATER_EN to add the HighWater output.
module return_stack
  import return_stack_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Depth     = 4,
  parameter int WrapMode  = WRAP_REJECT
) (
  input  logic            Clk,
  input  logic            Reset,
  return_stack_if.slave   bus
);

  localparam int PtrBits   = ptr_bits(Depth);
  localparam int CountBits = count_bits(Depth);
  localparam logic [PtrBits-1:0] PTR_ONE = PtrBits'(1);

  stack_op_e            op;
  logic                 ovf_set, udf_set;
  logic                 wr_en;
  logic [PtrBits-1:0]   wr_idx;
  logic [PtrBits-1:0]   top_ptr;
  logic [CountBits-1:0] count, count_next;
  logic                 full, empty;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] dout;

  return_stack_stack_pointer #(.Depth(Depth)) u_stack_pointer (
    .Clk        (Clk),
    .Reset      (Reset),
    .op         (op),
    .top_ptr    (top_ptr),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  // Resolve Push/Pop against Full/Empty into one operation plus error events
  always_comb begin
    op      = OP_IDLE;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (bus.Push && bus.Pop) begin
      if (empty) begin
        // nothing to pop, but the push still goes through
        op      = OP_PUSH;
        udf_set = 1'b1;
      end else begin
        op = OP_REPLACE;
      end
    end else if (bus.Push) begin
      if (!full) begin
        op = OP_PUSH;
      end else begin
        ovf_set = 1'b1;
        op      = (WrapMode == WRAP_CIRCULAR) ? OP_PUSH_WRAP : OP_REJECT;
      end
    end else if (bus.Pop) begin
      if (!empty) begin
        op = OP_POP;
      end else begin
        op      = OP_POP_EMPTY;
        udf_set = 1'b1;
      end
    end
  end

  // Write port: replace targets the current top, pushes the next free slot
  always_comb begin
    wr_en  = (op == OP_PUSH) || (op == OP_PUSH_WRAP) || (op == OP_REPLACE);
    wr_idx = (op == OP_REPLACE) ? (top_ptr - PTR_ONE) : top_ptr;
  end

  // Entry array; contents are deliberately left unreset
  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_idx] <= bus.DIn;
  end

  // Sticky flags: a new error in the same cycle as ErrClr wins
  always_comb begin
    overflow_d  = (bus.ErrClr ? 1'b0 : overflow_q)  | ovf_set;
    underflow_d = (bus.ErrClr ? 1'b0 : underflow_q) | udf_set;
  end

  // Error flag registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Top-of-stack read, forced to zero while the stack is empty
  always_comb begin
    dout = empty ? '0 : mem_q[top_ptr - PTR_ONE];
  end

  assign bus.DOut      = dout;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.Count     = count;
  assign bus.Overflow  = overflow_q;
  assign bus.Underflow = underflow_q;

`ifdef RSTK_HIGHWATER_EN
  logic [CountBits-1:0] highwater_q, highwater_d;

  // Track the largest count seen, picked up on the edge the count rises
  always_comb begin
    highwater_d = (count_next > highwater_q) ? count_next : highwater_q;
  end

  // High-water register, cleared only by reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) highwater_q <= '0;
    else        highwater_q <= highwater_d;
  end

  assign bus.HighWater = highwater_q;
`endif

endmodule

// File: tb/tb_return_stack.sv
// Testbench for return_stack: two instances (reject and circular full-policy)
// driven with identical stimulus and compared to an array-based stack model.
`timescale 1ns/1ps
module tb_return_stack;
  import return_stack_pkg::*;

  localparam int DW = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  return_stack_if #(.DataWidth(DW), .Depth(D)) bus0 ();
  return_stack_if #(.DataWidth(DW), .Depth(D)) bus1 ();

  return_stack #(.DataWidth(DW), .Depth(D), .WrapMode(WRAP_REJECT)) u_rej (
    .Clk(clk), .Reset(rst_n), .bus(bus0.slave)
  );
  return_stack #(.DataWidth(DW), .Depth(D), .WrapMode(WRAP_CIRCULAR)) u_wrap (
    .Clk(clk), .Reset(rst_n), .bus(bus1.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 = reject policy, 1 = circular policy.
  // st[m][0] is the oldest entry, st[m][sz-1] the top.
  int st [2][D];
  int sz [2];
  bit mov[2];
  bit muf[2];
  int mhw[2];

  // Sampled DUT outputs
  logic [DW-1:0] act_dout [2];
  logic [2:0]    act_cnt  [2];
  logic          act_empty[2];
  logic          act_full [2];
  logic          act_ov   [2];
  logic          act_uf   [2];
  logic [2:0]    act_hw   [2];

  function automatic int exp_dout(int m);
    return (sz[m] == 0) ? 0 : st[m][sz[m]-1];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      sz[m] = 0; mov[m] = 0; muf[m] = 0; mhw[m] = 0;
    end
  endtask

  task automatic model_step(bit push, bit pop, int din, bit clr);
    for (int m = 0; m < 2; m++) begin
      bit ov = 0;
      bit uf = 0;
      if (push && pop) begin
        if (sz[m] == 0) begin
          uf = 1; st[m][0] = din; sz[m] = 1;
        end else begin
          st[m][sz[m]-1] = din;
        end
      end else if (push) begin
        if (sz[m] < D) begin
          st[m][sz[m]] = din; sz[m]++;
        end else begin
          ov = 1;
          if (m == 1) begin
            for (int k = 0; k < D-1; k++) st[m][k] = st[m][k+1];
            st[m][D-1] = din;
          end
        end
      end else if (pop) begin
        if (sz[m] > 0) sz[m]--;
        else uf = 1;
      end
      if (clr) begin mov[m] = 0; muf[m] = 0; end
      mov[m] |= ov;
      muf[m] |= uf;
      if (sz[m] > mhw[m]) mhw[m] = sz[m];
    end
  endtask

  task automatic sample();
    act_dout[0] = bus0.DOut;  act_dout[1] = bus1.DOut;
    act_cnt[0]  = bus0.Count; act_cnt[1]  = bus1.Count;
    act_empty[0] = bus0.Empty; act_empty[1] = bus1.Empty;
    act_full[0]  = bus0.Full;  act_full[1]  = bus1.Full;
    act_ov[0] = bus0.Overflow;  act_ov[1] = bus1.Overflow;
    act_uf[0] = bus0.Underflow; act_uf[1] = bus1.Underflow;
`ifdef RSTK_HIGHWATER_EN
    act_hw[0] = bus0.HighWater; act_hw[1] = bus1.HighWater;
`else
    act_hw[0] = 3'd0; act_hw[1] = 3'd0;
`endif
  endtask

  // One clock: drive both instances, advance the model, sample after the edge
  task automatic drive(bit push, bit pop, int din, bit clr);
    bus0.Push = push; bus0.Pop = pop; bus0.DIn = DW'(din); bus0.ErrClr = clr;
    bus1.Push = push; bus1.Pop = pop; bus1.DIn = DW'(din); bus1.ErrClr = clr;
    @(posedge clk);
    model_step(push, pop, din, clr);
    #1;
    sample();
    $display("txn push=%0b pop=%0b din=%02h clr=%0b | rej dout=%02h cnt=%0d | wrap dout=%02h cnt=%0d",
             push, pop, din[7:0], clr, act_dout[0], act_cnt[0], act_dout[1], act_cnt[1]);
  endtask

  task automatic apply_reset();
    bus0.Push = 0; bus0.Pop = 0; bus0.DIn = '0; bus0.ErrClr = 0;
    bus1.Push = 0; bus1.Pop = 0; bus1.DIn = '0; bus1.ErrClr = 0;
    rst_n = 1'b0;
    #3;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    sample();
  endtask

  task automatic test_reset();
    apply_reset();
    for (int m = 0; m < 2; m++) begin
      n_checks++;
      if (act_empty[m] !== 1'b1 || act_full[m] !== 1'b0 || act_cnt[m] !== 3'd0 ||
          act_dout[m] !== 8'h00 || act_ov[m] !== 1'b0 || act_uf[m] !== 1'b0 || act_hw[m] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got empty=%0b full=%0b cnt=%0d dout=%02h ov=%0b uf=%0b hw=%0d, want 1 0 0 00 0 0 0",
                 m, act_empty[m], act_full[m], act_cnt[m], act_dout[m], act_ov[m], act_uf[m], act_hw[m]);
      end
    end
  endtask

  task automatic test_push_pop();
    apply_reset();
    drive(1, 0, 'h10, 0);
    drive(1, 0, 'h20, 0);
    drive(1, 0, 'h30, 0);
    n_checks++;
    if (bus0.DOut !== 8'h30 || bus0.Count !== 3'd3) begin
      n_fail++;
      $display("FAIL push3: got dout=%02h cnt=%0d, want 30 3", bus0.DOut, bus0.Count);
    end
    drive(0, 1, 0, 0);
    n_checks++;
    if (bus0.DOut !== 8'h20 || bus0.Count !== 3'd2) begin
      n_fail++;
      $display("FAIL pop1: got dout=%02h cnt=%0d, want 20 2", bus0.DOut, bus0.Count);
    end
  endtask

  task automatic test_overflow();
    int exp_rej [4];
    int exp_wrp [4];
    exp_rej = '{4, 3, 2, 1};
    exp_wrp = '{5, 4, 3, 2};
    apply_reset();
    for (int i = 1; i <= 4; i++) drive(1, 0, i, 0);
    n_checks++;
    if (bus0.Full !== 1'b1 || bus1.Full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_after_4: got rej=%0b wrap=%0b, want 1 1", bus0.Full, bus1.Full);
    end
    drive(1, 0, 5, 0);
    n_checks++;
    if (bus0.Overflow !== 1'b1 || bus0.DOut !== 8'h04 || bus0.Count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_reject: got ov=%0b dout=%02h cnt=%0d, want 1 04 4", bus0.Overflow, bus0.DOut, bus0.Count);
    end
    n_checks++;
    if (bus1.Overflow !== 1'b1 || bus1.DOut !== 8'h05 || bus1.Count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovf_wrap: got ov=%0b dout=%02h cnt=%0d, want 1 05 4", bus1.Overflow, bus1.DOut, bus1.Count);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bus0.DOut !== 8'(exp_rej[i]) || bus1.DOut !== 8'(exp_wrp[i])) begin
        n_fail++;
        $display("FAIL drain[%0d]: got rej=%02h wrap=%02h, want %02h %02h",
                 i, bus0.DOut, bus1.DOut, exp_rej[i], exp_wrp[i]);
      end
      drive(0, 1, 0, 0);
    end
    n_checks++;
    if (bus0.Empty !== 1'b1 || bus1.Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: got rej=%0b wrap=%0b, want 1 1", bus0.Empty, bus1.Empty);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(0, 1, 0, 0);
    n_checks++;
    if (bus0.Underflow !== 1'b1 || bus0.Count !== 3'd0 || bus0.DOut !== 8'h00) begin
      n_fail++;
      $display("FAIL udf_pop_empty: got uf=%0b cnt=%0d dout=%02h, want 1 0 00", bus0.Underflow, bus0.Count, bus0.DOut);
    end
    drive(0, 1, 0, 1);
    n_checks++;
    if (bus0.Underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_clr_race: got uf=%0b, want 1", bus0.Underflow);
    end
    drive(0, 0, 0, 1);
    n_checks++;
    if (bus0.Underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clear: got uf=%0b, want 0", bus0.Underflow);
    end
  endtask

  task automatic test_replace_and_reset();
    apply_reset();
    drive(1, 0, 'h10, 0);
    drive(1, 0, 'h20, 0);
    drive(1, 1, 'h55, 0);
    n_checks++;
    if (bus0.DOut !== 8'h55 || bus0.Count !== 3'd2 || bus0.Underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL replace: got dout=%02h cnt=%0d uf=%0b, want 55 2 0", bus0.DOut, bus0.Count, bus0.Underflow);
    end
`ifdef RSTK_HIGHWATER_EN
    n_checks++;
    if (bus0.HighWater !== 3'd2) begin
      n_fail++;
      $display("FAIL highwater_pre: got %0d, want 2", bus0.HighWater);
    end
`endif
    // hold Push&Pop active and drop reset between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus0.Count !== 3'd0 || bus0.Empty !== 1'b1 || bus1.Count !== 3'd0 || bus1.Empty !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d/%0d empty=%0b/%0b, want 0/0 1/1",
               bus0.Count, bus1.Count, bus0.Empty, bus1.Empty);
    end
`ifdef RSTK_HIGHWATER_EN
    n_checks++;
    if (bus0.HighWater !== 3'd0) begin
      n_fail++;
      $display("FAIL highwater_post: got %0d, want 0", bus0.HighWater);
    end
`endif
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      bit push = ($urandom_range(0, 99) < 55);
      bit pop  = ($urandom_range(0, 99) < 45);
      bit clr  = ($urandom_range(0, 99) < 10);
      int din  = int'($urandom_range(0, 255));
      drive(push, pop, din, clr);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (act_dout[m] !== 8'(exp_dout(m)) || act_cnt[m] !== 3'(sz[m]) ||
            act_empty[m] !== (sz[m] == 0) || act_full[m] !== (sz[m] == D) ||
            act_ov[m] !== mov[m] || act_uf[m] !== muf[m]) begin
          n_fail++;
          $display("FAIL random[%0d] inst%0d: got dout=%02h cnt=%0d e=%0b f=%0b ov=%0b uf=%0b, want %02h %0d %0b %0b %0b %0b",
                   i, m, act_dout[m], act_cnt[m], act_empty[m], act_full[m], act_ov[m], act_uf[m],
                   exp_dout(m), sz[m], (sz[m] == 0), (sz[m] == D), mov[m], muf[m]);
        end
`ifdef RSTK_HIGHWATER_EN
        n_checks++;
        if (act_hw[m] !== 3'(mhw[m])) begin
          n_fail++;
          $display("FAIL random_hw[%0d] inst%0d: got %0d, want %0d", i, m, act_hw[m], mhw[m]);
        end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
